// File: rtl/bus_arbiter_rr_pkg.sv
// Shared encodings for the N-port memory bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arb_pkg;

    // Arbitration mode encodings for the RR_MODE parameter.
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // The bus is either free or owned by exactly one port until bus_done.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Pointer width that stays legal for a single-port build.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Port-side and bus-side signal bundle of the memory bus arbiter.
// Latency: n/a (wiring only).
// Backpressure: start is held by a port until its own done pulse.
// Ports: addr/data/we/start per port (packed, port p at [p*W +: W]),
//        done/grant per port, q read data, bus_* towards the memory bus.
interface bus_arbiter_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] data;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS-1:0]        start;
    logic [NUM_PORTS-1:0]        done;
    logic [NUM_PORTS-1:0]        grant;
    logic [DATA_W-1:0]           q;
    logic [ADDR_W-1:0]           bus_addr;
    logic [DATA_W-1:0]           bus_data;
    logic                        bus_we;
    logic                        bus_start;
    logic [DATA_W-1:0]           bus_q;
    logic                        bus_done;

    // Arbiter side.
    modport slave (
        input  addr, data, we, start, bus_q, bus_done,
        output done, grant, q, bus_addr, bus_data, bus_we, bus_start
    );

    // Requesters plus memory bus, seen from outside the arbiter.
    modport master (
        output addr, data, we, start, bus_q, bus_done,
        input  done, grant, q, bus_addr, bus_data, bus_we, bus_start
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner selection: round-robin from ptr+1 or fixed lowest-index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
// Ports: req (eligible requests), ptr (last winner), mode -> win one-hot,
//        win_idx binary, any_valid.
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    input  logic                 mode,
    output logic [NUM_PORTS-1:0] win,
    output logic [PTR_W-1:0]     win_idx,
    output logic                 any_valid
);

    int base;

    // Two passes instead of a rotate: ports at or above base first, then
    // the wrapped ports below base. base may equal NUM_PORTS after the last
    // port won, in which case the first pass is empty and the search wraps.
    always_comb begin
        win       = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        base      = (mode == ARB_RR) ? int'(ptr) + 1 : 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!any_valid && req[p] && (p >= base)) begin
                any_valid = 1'b1;
                win[p]    = 1'b1;
                win_idx   = PTR_W'(p);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!any_valid && req[p] && (p < base)) begin
                any_valid = 1'b1;
                win[p]    = 1'b1;
                win_idx   = PTR_W'(p);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-port memory bus arbiter, round-robin or fixed priority, one owner until bus_done.
// Latency: start seen in IDLE -> grant/bus_start next edge; bus_done -> done same cycle.
// Backpressure: ports hold start until their done; one IDLE cycle between transactions.
// Ports: clk, reset (async, active-high), arb (slave modport: per-port addr/data/we/
//        start in, done/grant/q out; bus_addr/data/we/start out, bus_q/bus_done in).
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 1
) (
    input  logic            clk,
    input  logic            reset,
    bus_arbiter_rr_if.slave arb
);

    localparam int PTR_W = ptr_width(NUM_PORTS);

    arb_state_t           state;
    logic                 busy;
    logic [NUM_PORTS-1:0] grant_r;
    logic [NUM_PORTS-1:0] mask_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [ADDR_W-1:0]    bus_addr_r;
    logic [DATA_W-1:0]    bus_data_r;
    logic                 bus_we_r;

    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] win;
    logic [PTR_W-1:0]     win_idx;
    logic                 any_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_we;

    assign busy = (state == BUSY);

    // A port that just finished is blocked for exactly one cycle, so a
    // requester that is late dropping start cannot grab the bus back.
    assign elig = arb.start & ~mask_r;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req       (elig),
        .ptr       (ptr_r),
        .mode      ((RR_MODE != 0) ? ARB_RR : ARB_FIXED),
        .win       (win),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (win[p]) begin
                sel_addr = arb.addr[p*ADDR_W +: ADDR_W];
                sel_data = arb.data[p*DATA_W +: DATA_W];
                sel_we   = arb.we[p];
            end
        end
    end

    // Bus registers load only on the IDLE->BUSY edge, so port inputs are
    // don't-care while a transaction is in flight. bus_addr keeps its last
    // value while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_r    <= '0;
            mask_r     <= '0;
            ptr_r      <= PTR_W'(NUM_PORTS - 1);
            bus_addr_r <= '0;
            bus_data_r <= '0;
            bus_we_r   <= 1'b0;
        end else begin
            mask_r <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state      <= BUSY;
                        grant_r    <= win;
                        ptr_r      <= win_idx;
                        bus_addr_r <= sel_addr;
                        bus_data_r <= sel_data;
                        bus_we_r   <= sel_we;
                    end
                end
                BUSY: begin
                    if (arb.bus_done) begin
                        state   <= IDLE;
                        grant_r <= '0;
                        mask_r  <= grant_r;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // grant_r is zero while idle, so a stray bus_done cannot raise done.
    assign arb.done      = grant_r & {NUM_PORTS{busy & arb.bus_done}};
    assign arb.grant     = grant_r;
    assign arb.q         = arb.bus_q;
    assign arb.bus_addr  = bus_addr_r;
    assign arb.bus_data  = bus_data_r;
    assign arb.bus_we    = bus_we_r;
    assign arb.bus_start = busy & ~arb.bus_done;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: one round-robin and one fixed-priority instance.
// Latency: modelled bus answers bus_done on the 3rd cycle of bus_start.
// Backpressure: requesters hold start until their done (or one cycle longer).
module tb_bus_arbiter_rr;

    localparam int NP  = 4;
    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef struct {
        int          port;
        logic [26:0] addr;
        logic [31:0] data;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) if_rr ();
    bus_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) if_fx ();

    bus_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr (
        .clk   (clk),
        .reset (reset),
        .arb   (if_rr)
    );

    bus_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fx (
        .clk   (clk),
        .reset (reset),
        .arb   (if_fx)
    );

    // Bench-side drive state, index 0 = round-robin DUT, 1 = fixed DUT.
    logic [26:0] p_addr [2][NP];
    logic [31:0] p_data [2][NP];
    logic        p_we   [2][NP];
    logic [3:0]  st     [2];
    logic        bus_done_r [2];
    logic [31:0] bus_q_r    [2];

    for (genvar p = 0; p < NP; p++) begin : g_pack
        assign if_rr.addr[p*AW +: AW] = p_addr[0][p];
        assign if_rr.data[p*DW +: DW] = p_data[0][p];
        assign if_rr.we[p]            = p_we[0][p];
        assign if_fx.addr[p*AW +: AW] = p_addr[1][p];
        assign if_fx.data[p*DW +: DW] = p_data[1][p];
        assign if_fx.we[p]            = p_we[1][p];
    end
    assign if_rr.start    = st[0];
    assign if_fx.start    = st[1];
    assign if_rr.bus_done = bus_done_r[0];
    assign if_fx.bus_done = bus_done_r[1];
    assign if_rr.bus_q    = bus_q_r[0];
    assign if_fx.bus_q    = bus_q_r[1];

    // Flattened view of outputs so one monitor loop serves both DUTs.
    logic [3:0]  done_w  [2];
    logic [3:0]  grant_w [2];
    logic [31:0] q_w     [2];
    logic [26:0] baddr_w [2];
    logic [31:0] bdata_w [2];
    logic        bwe_w   [2];
    logic        bstart_w[2];
    assign done_w[0]   = if_rr.done;      assign done_w[1]   = if_fx.done;
    assign grant_w[0]  = if_rr.grant;     assign grant_w[1]  = if_fx.grant;
    assign q_w[0]      = if_rr.q;         assign q_w[1]      = if_fx.q;
    assign baddr_w[0]  = if_rr.bus_addr;  assign baddr_w[1]  = if_fx.bus_addr;
    assign bdata_w[0]  = if_rr.bus_data;  assign bdata_w[1]  = if_fx.bus_data;
    assign bwe_w[0]    = if_rr.bus_we;    assign bwe_w[1]    = if_fx.bus_we;
    assign bstart_w[0] = if_rr.bus_start; assign bstart_w[1] = if_fx.bus_start;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt [2] = '{0, 0};
    int last_done[2] = '{-100, -100};
    logic gap_chk [2] = '{1'b0, 1'b0};
    logic resp_en = 1'b1;
    int   resp_cnt[2] = '{0, 0};
    logic [3:0] prev_g[2] = '{4'd0, 4'd0};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_port(input int d, input int p, input logic [26:0] a,
                            input logic [31:0] dt, input logic w);
        p_addr[d][p] = a;
        p_data[d][p] = dt;
        p_we[d][p]   = w;
    endtask

    task automatic push_exp(input int d, input int p);
        exp_t e;
        e.port = p;
        e.addr = p_addr[d][p];
        e.data = p_data[d][p];
        e.we   = p_we[d][p];
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Returns at negedge+4 of the cycle where the n-th done of DUT d was seen.
    task automatic wait_done(input int d, input int n);
        int k;
        k = 0;
        while (done_cnt[d] < n && k < 300) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (done_cnt[d] < n) chk($sformatf("timeout_done%0d", d), 64'(done_cnt[d]), 64'(n));
    endtask

    // Bus model plus monitor/scoreboard, both DUTs.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    bus_done_r[d] = 1'b0;
                    resp_cnt[d]   = 0;
                end else if (resp_en) begin
                    if (bus_done_r[d]) begin
                        bus_done_r[d] = 1'b0;
                        resp_cnt[d]   = 0;
                    end else if (bstart_w[d]) begin
                        resp_cnt[d]++;
                        if (resp_cnt[d] == LAT) begin
                            bus_done_r[d] = 1'b1;
                            bus_q_r[d]    = $urandom;
                        end
                    end
                end
            end
            #3;
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                logic have;
                if (reset) begin
                    prev_g[d] = '0;
                end else begin
                    have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                    if (have) e = (d == 0) ? sb0[0] : sb1[0];
                    if (grant_w[d] != 0 && prev_g[d] == 0) begin
                        if (!have) chk($sformatf("unexp_grant%0d", d), 64'(grant_w[d]), 64'd0);
                        else begin
                            chk($sformatf("grant%0d", d), 64'(grant_w[d]), 64'(4'b1 << e.port));
                            chk($sformatf("bus_addr%0d", d), 64'(baddr_w[d]), 64'(e.addr));
                            chk($sformatf("bus_data%0d", d), 64'(bdata_w[d]), 64'(e.data));
                            chk($sformatf("bus_we%0d", d), 64'(bwe_w[d]), 64'(e.we));
                            if (gap_chk[d]) chk($sformatf("gap%0d", d), 64'(cyc - last_done[d]), 64'd2);
                        end
                    end
                    if (done_w[d] != 0) begin
                        if (!have) chk($sformatf("unexp_done%0d", d), 64'(done_w[d]), 64'd0);
                        else begin
                            if (d == 0) void'(sb0.pop_front());
                            else        void'(sb1.pop_front());
                            chk($sformatf("done%0d", d), 64'(done_w[d]), 64'(4'b1 << e.port));
                            chk($sformatf("q%0d", d), 64'(q_w[d]), 64'(bus_q_r[d]));
                            chk($sformatf("hold_addr%0d", d), 64'(baddr_w[d]), 64'(e.addr));
                            chk($sformatf("bus_start_at_done%0d", d), 64'(bstart_w[d]), 64'd0);
                        end
                        done_cnt[d]++;
                        last_done[d] = cyc;
                    end
                    prev_g[d] = grant_w[d];
                end
            end
            cyc++;
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++)
                set_port(d, p, 27'h100 + 27'(p), 32'hA000_0000 + 32'(p), p[0]);
            st[d]         = 4'b0000;
            bus_done_r[d] = 1'b0;
            bus_q_r[d]    = 32'h0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        #4;
        for (int d = 0; d < 2; d++) begin
            chk("rst_grant", 64'(grant_w[d]), 64'd0);
            chk("rst_bus_start", 64'(bstart_w[d]), 64'd0);
            chk("rst_bus_addr", 64'(baddr_w[d]), 64'd0);
            chk("rst_bus_we", 64'(bwe_w[d]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Idle with no requests, then a stray bus_done.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            chk("idle_grant", 64'(grant_w[0]), 64'd0);
            chk("idle_bus_start", 64'(bstart_w[0]), 64'd0);
        end
        resp_en = 1'b0;
        @(negedge clk);
        bus_done_r[0] = 1'b1;
        #4;
        chk("stray_done", 64'(done_w[0]), 64'd0);
        chk("stray_bus_start", 64'(bstart_w[0]), 64'd0);
        @(negedge clk);
        bus_done_r[0] = 1'b0;
        resp_en = 1'b1;
        #4;
        chk("stray_grant", 64'(grant_w[0]), 64'd0);

        // Round-robin, all ports held: 0,1,2,3,0 with one idle cycle between.
        @(negedge clk);
        foreach (sb0[i]) ;
        for (int p = 0; p < NP; p++) push_exp(0, p);
        push_exp(0, 0);
        st[0] = 4'b1111;
        wait_done(0, 1);
        gap_chk[0] = 1'b1;
        wait_done(0, 5);
        gap_chk[0] = 1'b0;
        @(negedge clk);
        st[0] = 4'b0000;

        // Fixed priority, ports 1 and 3 held: 1 first, then 3 during the
        // masked cycle, then 1 again while 3 is masked.
        @(negedge clk);
        push_exp(1, 1); push_exp(1, 3); push_exp(1, 1); push_exp(1, 3);
        st[1] = 4'b1010;
        wait_done(1, 4);
        @(negedge clk);
        st[1] = 4'b0000;

        // Fixed: port 0 keeps start one cycle past its done; port 1 goes next.
        @(negedge clk);
        push_exp(1, 0); push_exp(1, 1);
        st[1] = 4'b0011;
        wait_done(1, 5);
        @(negedge clk);
        @(negedge clk);
        st[1][0] = 1'b0;
        wait_done(1, 6);
        @(negedge clk);
        st[1] = 4'b0000;

        // Port 2 write; its inputs change while the bus is busy.
        @(negedge clk);
        set_port(0, 2, 27'h123, 32'hDEADBEEF, 1'b1);
        push_exp(0, 2);
        st[0] = 4'b0100;
        @(negedge clk);
        set_port(0, 2, 27'h7FF_FFFF, 32'h0, 1'b0);
        #4;
        chk("mid_grant", 64'(grant_w[0]), 64'h4);
        chk("mid_bus_addr", 64'(baddr_w[0]), 64'h123);
        chk("mid_bus_data", 64'(bdata_w[0]), 64'hDEADBEEF);
        chk("mid_bus_we", 64'(bwe_w[0]), 64'd1);
        wait_done(0, 6);
        @(negedge clk);
        st[0] = 4'b0000;

        // Reset while busy: pointer at 2, so port 3 owns the bus first.
        @(negedge clk);
        for (int p = 0; p < NP; p++)
            set_port(0, p, 27'h200 + 27'(p), 32'hB000_0000 + 32'(p), ~p[0]);
        push_exp(0, 3);
        st[0] = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #4;
        chk("pre_rst_bus_start", 64'(bstart_w[0]), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_busy_bus_start", 64'(bstart_w[0]), 64'd0);
        chk("rst_busy_grant", 64'(grant_w[0]), 64'd0);
        chk("rst_busy_done", 64'(done_w[0]), 64'd0);
        sb0.delete();
        @(negedge clk);
        @(negedge clk);
        push_exp(0, 0);
        reset = 1'b0;
        wait_done(0, 7);
        @(negedge clk);
        st[0] = 4'b0000;

        repeat (4) @(negedge clk);
        chk("sb0_empty", 64'(sb0.size()), 64'd0);
        chk("sb1_empty", 64'(sb1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
